skew_feed_sequencer: RTL
========================

# skew_feed_sequencer

Tile-feed sequencer upstream of the input skew stage of the systolic matmul array. On `start`, it first flushes the skew stage. It then reads `k_len` consecutive N-element rows from the operand buffer, which has a fixed read latency. It presents each row to the skew stage with a load strobe. Finally, it waits for the last row to drain through the deepest skew channel and pulses `done`.

## Interface
Parameters:
- `ARRAY_SIZE`, 32: vector width N; skew depth of the last channel is N-1.
- `DATA_WIDTH`, 16: element width (BF16).
- `ADDR_W`, 10: buffer address and row-count width.
- `RD_LATENCY`, 2: cycles from `buf_rd_en` to valid `buf_rd_data`; must be ≥1.

Ports:
- `clk` input 1: single clock, all logic on the rising edge.
- `rst` input 1: synchronous reset, active-high.
- `start` input 1: launch a tile; sampled only in IDLE.
- `k_len` input ADDR_W: number of rows to feed; sampled with `start`.
- `abort` input 1: cancel the tile in progress.
- `busy` output 1: high while a tile is active.
- `done` output 1: one-cycle pulse when the tile has fully drained.
- `buf_rd_en` output 1: operand buffer read strobe.
- `buf_rd_addr` output ADDR_W: row address.
- `buf_rd_data` input ARRAY_SIZE×DATA_WIDTH (signed unpacked array): row data, valid RD_LATENCY cycles after `buf_rd_en`.
- `skew_load_en` output 1: load strobe to the skew stage.
- `skew_flush` output 1: clear the skew stage shift registers.
- `skew_data` output ARRAY_SIZE×DATA_WIDTH (signed unpacked array): row to the skew stage.

## Operation
- States: IDLE, FLUSH, FEED, DRAIN.
- **IDLE:**
  - `start`=1 with `k_len`≠0: latch `k_len` as K and go to FLUSH.
  - `start`=1 with `k_len`=0: pulse `done` next cycle and stay IDLE. No flush, no reads, `busy` stays 0.
- **FLUSH** (1 cycle): `skew_flush`=1, `busy`=1, then go to FEED.
- **FEED** (K cycles):
  - `buf_rd_en`=1 with `buf_rd_addr` = 0,1,…,K-1, one per cycle.
  - After the read with address K-1, go to DRAIN.
- **Read-valid pipeline:** a RD_LATENCY-deep shift register tracks `buf_rd_en`.
  - `skew_load_en` = the pipeline output.
  - `skew_data` = `buf_rd_data` when `skew_load_en`=1, otherwise all-zero.
- **DRAIN:**
  - A counter runs RD_LATENCY + ARRAY_SIZE - 1 cycles after the last read.
  - This covers the last row's arrival plus propagation through channel N-1.
  - Then pulse `done`, drop `busy`, and return to IDLE.
- `start` while busy is ignored, including a `start` in the same cycle as `done`.
- **`abort`** (any non-IDLE state, highest priority after `rst`):
  - Next cycle: state = IDLE, `skew_flush`=1 for exactly one cycle.
  - The read-valid pipeline is cleared, so in-flight reads never raise `skew_load_en`.
  - No `done` pulse. `abort` in IDLE has no effect.
- **Reset:** all outputs 0, `buf_rd_addr`=0, pipeline and counters cleared, state IDLE.
  - Reset mid-tile discards everything and does not pulse `done`.
- **Arithmetic:**
  - Address counter is ADDR_W bits; it never wraps because K ≤ 2^ADDR_W - 1.
  - Drain counter width is ceil(log2(RD_LATENCY+ARRAY_SIZE)).

## Timing
- `start` accepted in cycle T, with K≥1:
  - T+1: `skew_flush`=1 and `busy` rises.
  - T+2 … T+1+K: `buf_rd_en`=1.
  - T+2+L … T+1+K+L: `skew_load_en`=1, where L = RD_LATENCY.
  - T+1+K+L+N: `done`=1, where N = ARRAY_SIZE; `busy` is 0 from T+2+K+L+N.
- `busy` is high from T+1 through the `done` cycle inclusive.
- Total `start`-to-`done` latency: K+L+N+1 cycles.
- Back-to-back: the earliest new `start` is the cycle after `done`. No overlap between tiles.
- `skew_load_en` is never high during `skew_flush`.
- All outputs are registered or decoded directly from state/pipeline registers. No combinational path from `start` or `abort` to any output.

## Test plan
- **Reset values:** assert `rst` for 3 cycles, then release → every output 0, state IDLE, `busy`=0.
- **Nominal tile:** N=4, L=2, K=3, buffer row r = {r*4+c}.
  - `start` at T → flush at T+1; reads addr 0,1,2 at T+2..T+4.
  - `skew_load_en` at T+4..T+6 with rows 0,1,2; `done` at T+10.
  - Scoreboard the skew stage output against the expected staggered diagonal.
- **Degenerate tiles:**
  - K=0 → `done` at T+1; no flush, no reads.
  - K=1 → single read at T+2; `done` at T+1+1+2+4 = T+8.
- **Abort mid-feed:** K=8, `abort` at T+4 → `skew_flush`=1 at T+5; no `skew_load_en` at or after T+5; no `done`.
  - A fresh `start` at T+6 runs a complete, correct tile.
- **Start collisions:** `start` pulsed every cycle for 40 cycles with K=5 → exactly one tile per `done`, consecutive tiles spaced K+L+N+2 cycles apart.
  - `start` in the `done` cycle is ignored.
- **Mid-tile reset:** `rst` during DRAIN → outputs 0 the next cycle, no `done`.
  - The next `start` completes normally.

Source files
------------

// File: rtl/skew_feed_sequencer.sv
// Tile-feed sequencer: flushes the skew stage, streams K operand rows from a
// fixed-latency buffer into it, then waits for the deepest skew channel to drain.
module skew_feed_sequencer #(
    parameter int ARRAY_SIZE = 32,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 10,
    parameter int RD_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            k_len,
    input  logic                         abort,
    output logic                         busy,
    output logic                         done,
    output logic                         buf_rd_en,
    output logic [ADDR_W-1:0]            buf_rd_addr,
    input  logic signed [DATA_WIDTH-1:0] buf_rd_data [ARRAY_SIZE],
    output logic                         skew_load_en,
    output logic                         skew_flush,
    output logic signed [DATA_WIDTH-1:0] skew_data [ARRAY_SIZE]
);

    // state  | meaning
    // IDLE   | waiting for start
    // FLUSH  | one-cycle clear of the skew shift registers
    // FEED   | one buffer read per cycle, addresses 0..K-1
    // DRAIN  | last row in flight / propagating through channel N-1
    typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_FEED, S_DRAIN} state_t;

    localparam int CNT_W = $clog2(RD_LATENCY + ARRAY_SIZE);
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(RD_LATENCY + ARRAY_SIZE - 1);

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       k_q, k_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [RD_LATENCY-1:0]   vld_q, vld_d;
    logic                    zdone_q, zdone_d;
    logic                    aflush_q, aflush_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            vld_q    <= '0;
            zdone_q  <= 1'b0;
            aflush_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            vld_q    <= vld_d;
            zdone_q  <= zdone_d;
            aflush_q <= aflush_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        zdone_d  = 1'b0;
        aflush_d = 1'b0;
        vld_d    = vld_q << 1;
        vld_d[0] = (state_q == S_FEED);

        case (state_q)
            S_IDLE: begin
                // a start landing on the zero-length done pulse is ignored
                if (start && !zdone_q) begin
                    if (k_len == '0) begin
                        zdone_d = 1'b1;
                    end else begin
                        k_d     = k_len;
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                addr_d  = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                if (addr_q == k_q - 1'b1) begin
                    addr_d  = '0;
                    cnt_d   = DRAIN_INIT;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            aflush_d = 1'b1;
            vld_d    = '0;
            addr_d   = '0;
            cnt_d    = '0;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = zdone_q || (state_q == S_DRAIN && cnt_q == '0);
    assign buf_rd_en    = (state_q == S_FEED);
    assign buf_rd_addr  = addr_q;
    assign skew_flush   = (state_q == S_FLUSH) || aflush_q;
    assign skew_load_en = vld_q[RD_LATENCY-1];

    always_comb begin
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            skew_data[i] = skew_load_en ? buf_rd_data[i] : '0;
        end
    end

endmodule
